// File: rtl/tty_char_buffer.sv
// tty_char_buffer: terminal-style character buffer with a pixel query port.
//
// Bytes arrive over a valid/ready handshake. Printable codes are written at a
// hardware cursor that auto-advances. CR, LF, BS and FF are interpreted as
// terminal controls. Scrolling rotates the logical-to-physical row mapping
// (top_row) instead of moving memory, so only the newly exposed row is blanked.
// A VGA-style pixel query returns the glyph bit with a blinking underline cursor
// overlaid, registered two cycles after the query.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     byte handshake, in_data = character or control byte
//   cursor_en             enable the cursor overlay
//   cursor_col/row        current cursor position (logical row)
//   busy                  clear or scroll fill in progress (= !in_ready)
//   pixel_hpos/vpos       queried pixel coordinate
//   pixel_color           pixel value, two cycles after its query
//
// character_rom: glyph lookup shared with the pixel path. The font is
// procedural: printable non-space codes show their own bit pattern rotated by
// (gx + gy); space, controls and codes above 0x7E are blank.

module character_rom #(
    parameter int GLYPH_W = 8,
    parameter int GLYPH_H = 16,
    parameter int GX_W    = $clog2(GLYPH_W),
    parameter int GY_W    = $clog2(GLYPH_H)
) (
    input  logic [7:0]      code,
    input  logic [GX_W-1:0] gx,
    input  logic [GY_W-1:0] gy,
    output logic            pixel
);
    logic [2:0] bit_sel;

    always_comb begin
        bit_sel = 3'(gx) + 3'(gy);
        pixel   = 1'b0;
        if (code >= 8'h21 && code <= 8'h7E) begin
            pixel = code[bit_sel];
        end
    end
endmodule

module tty_char_buffer #(
    parameter int CLK_FREQ          = 50_000_000,
    parameter int COLS              = 80,
    parameter int ROWS              = 25,
    parameter int GLYPH_W           = 8,
    parameter int GLYPH_H           = 16,
    parameter int PIXEL_HPOS_W      = 10,
    parameter int PIXEL_VPOS_W      = 10,
    parameter int CURSOR_BLINK_FREQ = 2,
    parameter int COL_W             = $clog2(COLS),
    parameter int ROW_W             = $clog2(ROWS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [7:0]              in_data,
    input  logic                    cursor_en,
    output logic [COL_W-1:0]        cursor_col,
    output logic [ROW_W-1:0]        cursor_row,
    output logic                    busy,
    input  logic [PIXEL_HPOS_W-1:0] pixel_hpos,
    input  logic [PIXEL_VPOS_W-1:0] pixel_vpos,
    output logic                    pixel_color
);
    localparam int CELLS        = COLS * ROWS;
    localparam int ADDR_W       = $clog2(CELLS);
    localparam int GX_W         = $clog2(GLYPH_W);
    localparam int GY_W         = $clog2(GLYPH_H);
    localparam int HPIX         = COLS * GLYPH_W;
    localparam int VPIX         = ROWS * GLYPH_H;
    localparam int BLINK_RELOAD = CLK_FREQ / (2 * CURSOR_BLINK_FREQ) - 1;
    localparam int BLINK_W      = (BLINK_RELOAD > 0) ? $clog2(BLINK_RELOAD + 1) : 1;

    localparam logic [ADDR_W-1:0]       COLS_A     = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0]       LAST_COL_A = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0]       LAST_CELL  = ADDR_W'(CELLS - 1);
    localparam logic [COL_W-1:0]        COL_MAX    = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]        ROW_MAX    = ROW_W'(ROWS - 1);
    localparam logic [ROW_W:0]          ROWS_X     = (ROW_W + 1)'(ROWS);
    localparam logic [PIXEL_HPOS_W:0]   HPIX_X     = (PIXEL_HPOS_W + 1)'(HPIX);
    localparam logic [PIXEL_VPOS_W:0]   VPIX_X     = (PIXEL_VPOS_W + 1)'(VPIX);
    localparam logic [GY_W-1:0]         GY_UL      = GY_W'(GLYPH_H - 2);
    localparam logic [BLINK_W-1:0]      BLINK_LOAD = BLINK_W'(BLINK_RELOAD);

    typedef enum logic [1:0] {IDLE, FILL_ROW, FILL_ALL} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   fill_q, fill_d;
    logic [ROW_W-1:0]    top_q, top_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
    logic                blink_on_q, blink_on_d;
    logic [GX_W-1:0]     gx_q, gx_d;
    logic [GY_W-1:0]     gy_q, gy_d;
    logic                active_q, active_d;
    logic                hit_q, hit_d;
    logic                pixel_color_q, pixel_color_d;

    logic [7:0]          mem [CELLS];
    logic [7:0]          rd_code_q;
    logic [ADDR_W-1:0]   rd_addr;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [7:0]          wr_data;
    logic                do_lf;
    logic                glyph_bit;
    logic [PIXEL_HPOS_W-1:0] ccol;
    logic [PIXEL_VPOS_W-1:0] crow;

    // (lrow + top) mod ROWS; both operands are already below ROWS.
    function automatic logic [ROW_W-1:0] phys_row(input logic [ROW_W-1:0] lrow,
                                                  input logic [ROW_W-1:0] top);
        logic [ROW_W:0] sum;
        sum = {1'b0, lrow} + {1'b0, top};
        if (sum >= ROWS_X) begin
            sum = sum - ROWS_X;
        end
        return sum[ROW_W-1:0];
    endfunction

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] prow,
                                                    input logic [COL_W-1:0] col);
        return ADDR_W'(prow) * COLS_A + ADDR_W'(col);
    endfunction

    always_comb begin
        state_d  = state_q;
        fill_d   = fill_q;
        top_d    = top_q;
        col_d    = col_q;
        row_d    = row_q;
        do_lf    = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = cell_addr(phys_row(row_q, top_q), col_q);
        wr_data  = in_data;
        in_ready = (state_q == IDLE);
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (in_data >= 8'h20 && in_data <= 8'h7E) begin
                        wr_en = 1'b1;
                        if (col_q == COL_MAX) begin
                            col_d = '0;
                            do_lf = 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end else begin
                        case (in_data)
                            8'h0D: col_d = '0;
                            8'h0A: do_lf = 1'b1;
                            8'h08: if (col_q != '0) col_d = col_q - 1'b1;
                            8'h0C: begin
                                state_d = FILL_ALL;
                                fill_d  = '0;
                            end
                            default: ;
                        endcase
                    end
                    if (do_lf) begin
                        if (row_q != ROW_MAX) begin
                            row_d = row_q + 1'b1;
                        end else begin
                            // Scroll: the old top physical row becomes the new bottom row.
                            top_d   = phys_row(ROW_W'(1), top_q);
                            state_d = FILL_ROW;
                            fill_d  = '0;
                        end
                    end
                end
            end
            FILL_ROW: begin
                // top_q has already advanced, so logical ROWS-1 maps to the exposed row.
                wr_en   = 1'b1;
                wr_data = 8'h20;
                wr_addr = cell_addr(phys_row(ROW_MAX, top_q), fill_q[COL_W-1:0]);
                fill_d  = fill_q + 1'b1;
                if (fill_q == LAST_COL_A) begin
                    state_d = IDLE;
                end
            end
            FILL_ALL: begin
                wr_en   = 1'b1;
                wr_data = 8'h20;
                wr_addr = fill_q;
                fill_d  = fill_q + 1'b1;
                if (fill_q == LAST_CELL) begin
                    state_d = IDLE;
                    top_d   = '0;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            default: begin
                state_d = FILL_ALL;
                fill_d  = '0;
            end
        endcase
    end

    always_comb begin
        blink_cnt_d = blink_cnt_q - 1'b1;
        blink_on_d  = blink_on_q;
        if (blink_cnt_q == '0) begin
            blink_cnt_d = BLINK_LOAD;
            blink_on_d  = ~blink_on_q;
        end
    end

    // Pixel stage 1: split the coordinate into cell and glyph offsets, issue the read.
    always_comb begin
        ccol     = pixel_hpos >> GX_W;
        crow     = pixel_vpos >> GY_W;
        gx_d     = pixel_hpos[GX_W-1:0];
        gy_d     = pixel_vpos[GY_W-1:0];
        active_d = ({1'b0, pixel_hpos} < HPIX_X) && ({1'b0, pixel_vpos} < VPIX_X);
        rd_addr  = '0;
        if (active_d) begin
            rd_addr = cell_addr(phys_row(crow[ROW_W-1:0], top_q), ccol[COL_W-1:0]);
        end
        hit_d = cursor_en && blink_on_q
                && (ccol == PIXEL_HPOS_W'(col_q))
                && (crow == PIXEL_VPOS_W'(row_q))
                && (gy_d >= GY_UL);
        pixel_color_d = active_q & (glyph_bit ^ hit_q);
    end

    character_rom #(
        .GLYPH_W (GLYPH_W),
        .GLYPH_H (GLYPH_H)
    ) u_rom (
        .code  (rd_code_q),
        .gx    (gx_q),
        .gy    (gy_q),
        .pixel (glyph_bit)
    );

    // Read uses the pre-write contents when addresses collide.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_code_q <= mem[rd_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= FILL_ALL;
            fill_q        <= '0;
            top_q         <= '0;
            col_q         <= '0;
            row_q         <= '0;
            blink_cnt_q   <= '0;
            blink_on_q    <= 1'b1;
            gx_q          <= '0;
            gy_q          <= '0;
            active_q      <= 1'b0;
            hit_q         <= 1'b0;
            pixel_color_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            fill_q        <= fill_d;
            top_q         <= top_d;
            col_q         <= col_d;
            row_q         <= row_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_on_q    <= blink_on_d;
            gx_q          <= gx_d;
            gy_q          <= gy_d;
            active_q      <= active_d;
            hit_q         <= hit_d;
            pixel_color_q <= pixel_color_d;
        end
    end

    assign cursor_col  = col_q;
    assign cursor_row  = row_q;
    assign busy        = ~in_ready;
    assign pixel_color = pixel_color_q;
endmodule

// File: tb/tb_tty_char_buffer.sv
// Testbench for tty_char_buffer: a 16x4 screen model with a scoreboard for
// cursor updates and pixel queries, checked by a monitor on the falling edge.
module tb_tty_char_buffer;
    localparam int COLS  = 16;
    localparam int ROWS  = 4;
    localparam int GW    = 8;
    localparam int GH    = 16;
    localparam int CELLS = COLS * ROWS;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       cursor_en = 1'b0;
    logic [3:0] cursor_col;
    logic [1:0] cursor_row;
    logic       busy;
    logic [9:0] pixel_hpos = '0;
    logic [9:0] pixel_vpos = '0;
    logic       pixel_color;

    always #5 clk = ~clk;

    tty_char_buffer #(
        .CLK_FREQ          (1000),
        .COLS              (COLS),
        .ROWS              (ROWS),
        .GLYPH_W           (GW),
        .GLYPH_H           (GH),
        .PIXEL_HPOS_W      (10),
        .PIXEL_VPOS_W      (10),
        .CURSOR_BLINK_FREQ (250)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .cursor_en   (cursor_en),
        .cursor_col  (cursor_col),
        .cursor_row  (cursor_row),
        .busy        (busy),
        .pixel_hpos  (pixel_hpos),
        .pixel_vpos  (pixel_vpos),
        .pixel_color (pixel_color)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    byte unsigned scr [ROWS][COLS];
    int          mcol = 0;
    int          mrow = 0;
    int          cur_q [$];
    bit          pix_q [$];
    int          edges;
    bit          query_on = 1'b0;
    bit          cur_pend = 1'b0;
    bit          pix_d1 = 1'b0;
    bit          pix_d2 = 1'b0;

    // Clock edges since reset release; the blink phase is derived from this.
    always @(posedge clk or posedge rst) begin
        if (rst) edges <= 0;
        else     edges <= edges + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic bit glyph(input int code, input int gx, input int gy);
        if (code < 'h21 || code > 'h7E) return 1'b0;
        return 1'((code >> ((gx + gy) % 8)) & 1);
    endfunction

    // Reload 1 => blink toggles at edges 1, 3, 5, ... after release.
    function automatic bit blink_after(input int k);
        return (((k + 1) / 2) % 2) == 0;
    endfunction

    function automatic void model_clear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                scr[r][c] = 8'h20;
        mcol = 0;
        mrow = 0;
    endfunction

    // Applies one accepted byte to the screen model; returns expected busy cycles.
    function automatic int model_byte(input logic [7:0] b);
        bit lf = 1'b0;
        int busy_n = 0;
        if (b == 8'h0C) begin
            cur_q.push_back((mcol << 8) | mrow);
            model_clear();
            return CELLS;
        end
        if (b >= 8'h20 && b <= 8'h7E) begin
            scr[mrow][mcol] = b;
            if (mcol == COLS - 1) begin
                mcol = 0;
                lf   = 1'b1;
            end else begin
                mcol++;
            end
        end else if (b == 8'h0D) begin
            mcol = 0;
        end else if (b == 8'h0A) begin
            lf = 1'b1;
        end else if (b == 8'h08) begin
            if (mcol > 0) mcol--;
        end
        if (lf) begin
            if (mrow < ROWS - 1) begin
                mrow++;
            end else begin
                for (int r = 0; r < ROWS - 1; r++)
                    for (int c = 0; c < COLS; c++)
                        scr[r][c] = scr[r+1][c];
                for (int c = 0; c < COLS; c++)
                    scr[ROWS-1][c] = 8'h20;
                busy_n = COLS;
            end
        end
        cur_q.push_back((mcol << 8) | mrow);
        return busy_n;
    endfunction

    function automatic bit exp_pixel(input int h, input int v, input bit en);
        int cc, cr, gx, gy;
        bit hit;
        if (h >= COLS * GW || v >= ROWS * GH) return 1'b0;
        cc  = h / GW;
        cr  = v / GH;
        gx  = h % GW;
        gy  = v % GH;
        hit = en && blink_after(edges) && cc == mcol && cr == mrow && gy >= GH - 2;
        return glyph(scr[cr][cc], gx, gy) ^ hit;
    endfunction

    always @(negedge clk) begin
        int e;
        bit p;
        if (rst) begin
            cur_pend = 1'b0;
            pix_d1   = 1'b0;
            pix_d2   = 1'b0;
        end else begin
            if (cur_pend) begin
                if (cur_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL cursor_scoreboard: got unexpected acceptance, required none queued");
                end else begin
                    e = cur_q.pop_front();
                    check("cursor_col", int'(cursor_col), e >> 8);
                    check("cursor_row", int'(cursor_row), e & 255);
                end
            end
            cur_pend = in_valid && in_ready;
            if (pix_d2) begin
                if (pix_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL pixel_scoreboard: got output with no query queued");
                end else begin
                    p = pix_q.pop_front();
                    check("pixel_color", int'(pixel_color), int'(p));
                end
            end
            pix_d2 = pix_d1;
            pix_d1 = query_on;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic measure_busy(input string name, input int exp);
        int low = 0;
        int bz  = 0;
        while (!in_ready && low < 5000) begin
            if (busy) bz++;
            low++;
            tick();
        end
        check({name, "_ready_low_cycles"}, low, exp);
        check({name, "_busy_cycles"}, bz, exp);
    endtask

    task automatic do_reset(input int hold);
        rst      = 1'b1;
        in_valid = 1'b0;
        query_on = 1'b0;
        repeat (hold) tick();
        cur_q.delete();
        pix_q.delete();
        model_clear();
        rst = 1'b0;
        check("reset_pixel_color", int'(pixel_color), 0);
        measure_busy("reset", CELLS);
        check("reset_cursor_col", int'(cursor_col), 0);
        check("reset_cursor_row", int'(cursor_row), 0);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit measure);
        int n = 0;
        int exp_busy;
        while (!in_ready && n < 5000) begin
            tick();
            n++;
        end
        if (n >= 5000) check("send_wait_ready", int'(in_ready), 1);
        in_valid = 1'b1;
        in_data  = b;
        exp_busy = model_byte(b);
        tick();
        in_valid = 1'b0;
        if (measure) measure_busy("after_byte", exp_busy);
    endtask

    task automatic query(input int h, input int v, input bit en);
        pixel_hpos = 10'(h);
        pixel_vpos = 10'(v);
        cursor_en  = en;
        pix_q.push_back(exp_pixel(h, v, en));
        query_on = 1'b1;
        tick();
    endtask

    task automatic drain();
        query_on = 1'b0;
        repeat (3) tick();
    endtask

    // One random pixel inside every cell, overlay off.
    task automatic scan_cells();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                query(c * GW + $urandom_range(0, GW - 1), r * GH + $urandom_range(0, GH - 1), 1'b0);
        drain();
    endtask

    function automatic logic [7:0] rand_byte();
        int r = $urandom_range(0, 99);
        if (r < 60) return 8'($urandom_range(32, 126));
        if (r < 70) return 8'h0D;
        if (r < 82) return 8'h0A;
        if (r < 90) return 8'h08;
        if (r < 92) return 8'h0C;
        if (r < 96) return 8'h07;
        return 8'($urandom_range(127, 255));
    endfunction

    initial begin
        #800_000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset(3);
        for (int k = 0; k < 60; k++)
            query($urandom_range(0, 150), $urandom_range(0, 80), 1'b0);
        drain();

        send_byte(8'h41, 1'b1);
        send_byte(8'h42, 1'b1);
        check("ab_cursor_col", int'(cursor_col), 2);
        for (int v = 0; v < GH; v++)
            for (int h = 0; h < GW; h++)
                query(h, v, 1'b0);
        drain();

        for (int i = 0; i < 300; i++) begin
            send_byte(rand_byte(), 1'b1);
            if (i % 25 == 24) begin
                for (int k = 0; k < 40; k++)
                    query($urandom_range(0, 140), $urandom_range(0, 70), 1'($urandom_range(0, 1)));
                drain();
            end
        end

        send_byte(8'h0C, 1'b1);
        for (int r = 0; r < ROWS - 1; r++) begin
            for (int c = 0; c < 5; c++) send_byte(8'h61 + 8'(r * 5 + c), 1'b1);
            send_byte(8'h0D, 1'b1);
            send_byte(8'h0A, 1'b1);
        end
        for (int c = 0; c < COLS; c++) send_byte(8'h30 + 8'(c), 1'b1);
        check("wrap_cursor_col", int'(cursor_col), 0);
        check("wrap_cursor_row", int'(cursor_row), ROWS - 1);
        scan_cells();

        send_byte(8'h0D, 1'b1);
        send_byte(8'h08, 1'b1);
        send_byte(8'h07, 1'b1);
        check("ctrl_cursor_col", int'(cursor_col), 0);
        scan_cells();

        for (int k = 0; k < 8; k++) query(3, (ROWS - 1) * GH + 14, 1'b1);
        for (int k = 0; k < 4; k++) query(3, (ROWS - 1) * GH + 13, 1'b1);
        for (int k = 0; k < 4; k++) query(5, (ROWS - 1) * GH + 15, 1'b1);
        drain();

        send_byte(8'h0D, 1'b1);
        send_byte(8'h0A, 1'b1);
        send_byte(8'h0C, 1'b0);
        repeat (5) tick();
        do_reset(2);
        scan_cells();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
